// File: rtl/cpu_clk_ctrl.sv
// Clock-enable and reset controller for the multicycle core: stretched reset,
// debounced single-step / N-step burst / free-run enable, enabled-cycle counter.
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_STRETCH   = 8,
  parameter int STEP_WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_mode,
  input  logic                  step_btn,
  input  logic [STEP_WIDTH-1:0] burst_count,
  output logic                  cpu_en,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic [15:0]           cycle_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STW = $clog2(RESET_STRETCH + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STW-1:0] ST_LAST = STW'(RESET_STRETCH - 1);

  typedef enum logic [1:0] {
    RST_HOLD,
    IDLE,
    RUN,
    BURST
  } state_e;

  state_e                state_q, state_d;
  logic                  rst_s1_q, rst_s1_d;
  logic                  rst_s2_q, rst_s2_d;
  logic                  run_s1_q, run_s1_d;
  logic                  run_s2_q, run_s2_d;
  logic                  step_s1_q, step_s1_d;
  logic                  step_s2_q, step_s2_d;
  logic [DBW-1:0]        db_cnt_q, db_cnt_d;
  logic                  db_lvl_q, db_lvl_d;
  logic                  step_evt_q, step_evt_d;
  logic [STW-1:0]        st_cnt_q, st_cnt_d;
  logic [STEP_WIDTH-1:0] rem_q, rem_d;
  logic [STEP_WIDTH-1:0] burst_n;
  logic                  cpu_en_q, cpu_en_d;
  logic                  rst_n_q, rst_n_d;
  logic                  busy_q, busy_d;
  logic [15:0]           cyc_q, cyc_d;

  always_comb begin
    rst_s1_d  = 1'b1;
    rst_s2_d  = rst_s1_q;
    run_s1_d  = run_mode;
    run_s2_d  = run_s1_q;
    step_s1_d = step_btn;
    step_s2_d = step_s1_q;

    // Event is registered on the cycle the level rises, so it is a 1-cycle pulse
    db_cnt_d   = '0;
    db_lvl_d   = db_lvl_q;
    step_evt_d = 1'b0;
    if (step_s2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d   = step_s2_q;
        step_evt_d = step_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    burst_n = (burst_count == '0) ? STEP_WIDTH'(1) : burst_count;

    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    rem_d    = rem_q;
    unique case (state_q)
      RST_HOLD: begin
        if (rst_s2_q) begin
          if (st_cnt_q == ST_LAST) state_d = IDLE;
          else st_cnt_d = st_cnt_q + STW'(1);
        end
      end
      IDLE: begin
        if (run_s2_q) begin
          state_d = RUN;
        end else if (step_evt_q) begin
          rem_d   = burst_n;
          state_d = BURST;
        end
      end
      RUN: begin
        if (!run_s2_q) state_d = IDLE;
      end
      BURST: begin
        if (rem_q == STEP_WIDTH'(1)) state_d = IDLE;
        else rem_d = rem_q - STEP_WIDTH'(1);
      end
      default: state_d = RST_HOLD;
    endcase

    cpu_en_d = (state_d == RUN) || (state_d == BURST);
    busy_d   = cpu_en_d;
    rst_n_d  = (state_d != RST_HOLD);
    cyc_d    = cyc_q + {15'd0, cpu_en_q};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_HOLD;
      rst_s1_q   <= 1'b0;
      rst_s2_q   <= 1'b0;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      db_cnt_q   <= '0;
      db_lvl_q   <= 1'b0;
      step_evt_q <= 1'b0;
      st_cnt_q   <= '0;
      rem_q      <= '0;
      cpu_en_q   <= 1'b0;
      rst_n_q    <= 1'b0;
      busy_q     <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_s1_q   <= rst_s1_d;
      rst_s2_q   <= rst_s2_d;
      run_s1_q   <= run_s1_d;
      run_s2_q   <= run_s2_d;
      step_s1_q  <= step_s1_d;
      step_s2_q  <= step_s2_d;
      db_cnt_q   <= db_cnt_d;
      db_lvl_q   <= db_lvl_d;
      step_evt_q <= step_evt_d;
      st_cnt_q   <= st_cnt_d;
      rem_q      <= rem_d;
      cpu_en_q   <= cpu_en_d;
      rst_n_q    <= rst_n_d;
      busy_q     <= busy_d;
      cyc_q      <= cyc_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign cpu_reset_n = rst_n_q;
  assign busy        = busy_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: each expected enable run is queued by the stimulus,
// and a negedge monitor pops and checks it when the DUT ends a run.
module tb_cpu_clk_ctrl;

  logic        clock;
  logic        reset;
  logic        run_mode;
  logic        step_btn;
  logic [7:0]  burst_count;
  logic        cpu_en;
  logic        cpu_reset_n;
  logic        busy;
  logic [15:0] cycle_count;

  cpu_clk_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .run_mode    (run_mode),
    .step_btn    (step_btn),
    .burst_count (burst_count),
    .cpu_en      (cpu_en),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int start;
    int len;
    int total;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   run_start = 0;
  logic en_prev = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: an enable run is delimited by cpu_en rising and falling
  always @(negedge clock) begin
    exp_t e;
    if (cpu_en && !en_prev) begin
      run_start = cyc;
      chk("busy_on", int'(busy), 1);
    end
    if (!cpu_en && en_prev) begin
      chk("busy_off", int'(busy), 0);
      if (q.size() == 0) begin
        chk("unexpected_run_start", run_start, -1);
      end else begin
        e = q.pop_front();
        chk("run_start", run_start, e.start);
        chk("run_len", cyc - run_start, e.len);
        chk("run_total", int'(cycle_count), e.total);
      end
    end
    en_prev = cpu_en;
  end

  initial begin
    int k;
    int r;
    reset = 1'b0;
    run_mode = 1'b0;
    step_btn = 1'b0;
    burst_count = 8'd0;

    // Reset and stretch
    repeat (3) tick();
    chk("rst_en", int'(cpu_en), 0);
    chk("rst_rstn", int'(cpu_reset_n), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(cycle_count), 0);
    reset = 1'b1;
    r = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("stretch_rstn", int'(cpu_reset_n), (cyc >= r + 9) ? 1 : 0);
      chk("stretch_en", int'(cpu_en), 0);
    end
    chk("stretch_count", int'(cycle_count), 0);

    // Single step, burst_count 0 treated as 1
    burst_count = 8'd0;
    step_btn = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 6, 1, 1});
    repeat (10) tick();
    step_btn = 1'b0;
    repeat (12) tick();

    // Bouncing input is rejected, then a clean press bursts 5
    burst_count = 8'd5;
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      repeat (2) tick();
      step_btn = 1'b0;
      repeat (2) tick();
    end
    step_btn = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 6, 5, 6});
    repeat (12) tick();
    step_btn = 1'b0;
    repeat (10) tick();

    // Second press lands mid-burst and is discarded
    burst_count = 8'd12;
    step_btn = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 6, 12, 18});
    repeat (4) tick();
    step_btn = 1'b0;
    repeat (5) tick();
    step_btn = 1'b1;
    repeat (12) tick();
    step_btn = 1'b0;
    repeat (15) tick();

    // Free run for 100 cycles
    run_mode = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 2, 100, 118});
    repeat (100) tick();
    run_mode = 1'b0;
    repeat (10) tick();

    // run_mode rises during a 20-cycle burst
    burst_count = 8'd20;
    step_btn = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 6, 20, 138});
    q.push_back('{k + 27, 15, 153});
    repeat (10) tick();
    run_mode = 1'b1;
    step_btn = 1'b0;
    repeat (30) tick();
    run_mode = 1'b0;
    repeat (10) tick();

    // Clear counter, then wrap it
    reset = 1'b0;
    #1;
    chk("clr_count", int'(cycle_count), 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("clr_rstn", int'(cpu_reset_n), 1);
    run_mode = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 2, 65540, 4});
    repeat (65540) tick();
    run_mode = 1'b0;
    repeat (10) tick();
    chk("wrap_count", int'(cycle_count), 4);

    // Asynchronous reset in the middle of RUN
    run_mode = 1'b1;
    k = cyc + 1;
    q.push_back('{k + 2, 9, 0});
    repeat (12) tick();
    reset = 1'b0;
    #1;
    chk("async_en", int'(cpu_en), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_count", int'(cycle_count), 0);
    chk("async_rstn", int'(cpu_reset_n), 0);
    run_mode = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (15) tick();

    chk("pending_runs", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
